// File: rtl/fifo_word_serializer.sv
// Word-to-slice serializer between a fifo read port and a narrow link, plus the generic fifo.
// Latency 1 (word accepted -> first slice); a stalled output holds the slice and blocks new words.

// Generic synchronous fifo, power-of-two depth, registered occupancy.
// Latency 1 (push -> pop_vld); push_rdy drops when full, pop_dat valid while pop_vld.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  output logic                     push_rdy,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_fire;
  logic             pop_fire;

  assign push_rdy  = (count != (AW+1)'(DEPTH));
  assign pop_vld   = (count != '0);
  assign pop_dat   = mem[rd_ptr];
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_vld && pop_rdy;

  // Storage is not reset; pop_vld gates every read of it.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Splits each DATA_SIZE word into DATA_SIZE/OUT_SIZE slices, one per clock when unstalled.
// Latency 1 (input transfer -> first slice); back-to-back words without a bubble.
// Backpressure: ser_out_rtr low freezes the slice; next word accepted only with the last slice.
module fifo_word_serializer #(
  parameter int DATA_SIZE = 32,
  parameter int OUT_SIZE  = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] ser_inp_data,
  input  logic                 ser_inp_rts,
  output logic                 ser_inp_rtr,
  output logic [OUT_SIZE-1:0]  ser_out_data,
  output logic                 ser_out_rts,
  input  logic                 ser_out_rtr,
  output logic                 ser_out_last,
  output logic                 ser_busy
);
  localparam int RATIO = DATA_SIZE / OUT_SIZE;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [DATA_SIZE-1:0] shreg_q;
  logic [DATA_SIZE-1:0] shreg_d;
  logic [DATA_SIZE-1:0] shreg_shifted;
  logic [OUT_SIZE-1:0]  head_slice;
  logic                 in_xfer;
  logic                 out_xfer;

  // The outgoing slice always sits at the output end of the register.
  assign head_slice    = LSB_FIRST ? shreg_q[OUT_SIZE-1:0] : shreg_q[DATA_SIZE-1 -: OUT_SIZE];
  assign shreg_shifted = LSB_FIRST ? (shreg_q >> OUT_SIZE) : (shreg_q << OUT_SIZE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    ser_busy     = (state_q == SEND);
    ser_out_rts  = ser_busy;
    ser_out_last = ser_busy && (cnt_q == LAST_CNT);
    ser_out_data = ser_busy ? head_slice : '0;
    // Combinational ser_out_rtr -> ser_inp_rtr lets the next word load on the last slice.
    ser_inp_rtr  = !ser_busy || (ser_out_last && ser_out_rtr);
    in_xfer      = ser_inp_rts && ser_inp_rtr;
    out_xfer     = ser_out_rts && ser_out_rtr;

    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          shreg_d = ser_inp_data;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (ser_out_last) begin
            cnt_d = '0;
            if (in_xfer) begin
              shreg_d = ser_inp_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: MSB-first and LSB-first serializers on shared stimulus, plus fifo-fed stream.
module tb_fifo_word_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] drv_data = '0;
  logic        drv_rts = 1'b0;
  logic        drv_rtr = 1'b0;
  logic        use_fifo = 1'b0;

  logic [31:0] m_inp_data;
  logic        m_inp_rts;
  logic        m_inp_rtr, m_rts, m_last, m_busy;
  logic [7:0]  m_data;
  logic        l_inp_rtr, l_rts, l_last, l_busy;
  logic [7:0]  l_data;

  logic        push_vld = 1'b0;
  logic        push_rdy;
  logic [31:0] push_dat = '0;
  logic        pop_vld;
  logic        pop_rdy;
  logic [31:0] pop_dat;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign m_inp_data = use_fifo ? pop_dat : drv_data;
  assign m_inp_rts  = use_fifo ? pop_vld : drv_rts;
  assign pop_rdy    = use_fifo && m_inp_rtr;

  fifo #(.WIDTH(32), .DEPTH(4)) u_fifo (
    .clk(clk), .rst_n(rst),
    .push_vld(push_vld), .push_rdy(push_rdy), .push_dat(push_dat),
    .pop_vld(pop_vld), .pop_rdy(pop_rdy), .pop_dat(pop_dat),
    .count(fifo_count)
  );

  fifo_word_serializer #(.DATA_SIZE(32), .OUT_SIZE(8), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst),
    .ser_inp_data(m_inp_data), .ser_inp_rts(m_inp_rts), .ser_inp_rtr(m_inp_rtr),
    .ser_out_data(m_data), .ser_out_rts(m_rts), .ser_out_rtr(drv_rtr),
    .ser_out_last(m_last), .ser_busy(m_busy)
  );

  fifo_word_serializer #(.DATA_SIZE(32), .OUT_SIZE(8), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst),
    .ser_inp_data(drv_data), .ser_inp_rts(drv_rts), .ser_inp_rtr(l_inp_rtr),
    .ser_out_data(l_data), .ser_out_rts(l_rts), .ser_out_rtr(drv_rtr),
    .ser_out_last(l_last), .ser_busy(l_busy)
  );

  typedef struct {
    logic        rts;
    logic [31:0] dat;
    logic        rtr;
    logic        e_rts;
    logic [7:0]  e_m;
    logic [7:0]  e_l;
    logic        e_last;
    logic        e_irtr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rts, input logic [31:0] dat, input logic rtr, input logic e_rts,
                     input logic [7:0] e_m, input logic [7:0] e_l, input logic e_last,
                     input logic e_irtr);
    vec_t v;
    v.rts = rts; v.dat = dat; v.rtr = rtr; v.e_rts = e_rts;
    v.e_m = e_m; v.e_l = e_l; v.e_last = e_last; v.e_irtr = e_irtr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_rts, input logic [7:0] e_m,
                          input logic [7:0] e_l, input logic e_last);
    chk({tag, " m_rts"}, {31'd0, m_rts}, {31'd0, e_rts});
    chk({tag, " m_busy"}, {31'd0, m_busy}, {31'd0, e_rts});
    chk({tag, " m_data"}, {24'd0, m_data}, {24'd0, e_m});
    chk({tag, " m_last"}, {31'd0, m_last}, {31'd0, e_last});
    chk({tag, " l_rts"}, {31'd0, l_rts}, {31'd0, e_rts});
    chk({tag, " l_busy"}, {31'd0, l_busy}, {31'd0, e_rts});
    chk({tag, " l_data"}, {24'd0, l_data}, {24'd0, e_l});
    chk({tag, " l_last"}, {31'd0, l_last}, {31'd0, e_last});
  endtask

  task automatic apply_range(input int first, input int last);
    for (int i = first; i < last; i++) begin
      @(posedge clk); #1;
      drv_rts  = vq[i].rts;
      drv_data = vq[i].dat;
      drv_rtr  = vq[i].rtr;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vq[i].e_rts, vq[i].e_m, vq[i].e_l, vq[i].e_last);
      chk($sformatf("vec%0d m_inp_rtr", i), {31'd0, m_inp_rtr}, {31'd0, vq[i].e_irtr});
      chk($sformatf("vec%0d l_inp_rtr", i), {31'd0, l_inp_rtr}, {31'd0, vq[i].e_irtr});
    end
  endtask

  logic [31:0] words [16];
  logic [7:0]  exp_bytes [64];

  initial begin
    int s_main, s_caf, s_post, s_end;
    int pushed, got;
    logic push_fire;

    // Single word, back-to-back pair, and a three-cycle stall on the second slice.
    s_main = vq.size();
    add(1, 32'h11223344, 1, 0, 8'h00, 8'h00, 0, 1);
    add(0, 32'h0,        1, 1, 8'h11, 8'h44, 0, 0);
    add(0, 32'h0,        1, 1, 8'h22, 8'h33, 0, 0);
    add(0, 32'h0,        1, 1, 8'h33, 8'h22, 0, 0);
    add(0, 32'h0,        1, 1, 8'h44, 8'h11, 1, 1);
    add(0, 32'h0,        1, 0, 8'h00, 8'h00, 0, 1);
    add(1, 32'hA1B2C3D4, 1, 0, 8'h00, 8'h00, 0, 1);
    add(1, 32'h01020304, 1, 1, 8'hA1, 8'hD4, 0, 0);
    add(1, 32'h01020304, 1, 1, 8'hB2, 8'hC3, 0, 0);
    add(1, 32'h01020304, 1, 1, 8'hC3, 8'hB2, 0, 0);
    add(1, 32'h01020304, 1, 1, 8'hD4, 8'hA1, 1, 1);
    add(0, 32'h0,        1, 1, 8'h01, 8'h04, 0, 0);
    add(0, 32'h0,        1, 1, 8'h02, 8'h03, 0, 0);
    add(0, 32'h0,        1, 1, 8'h03, 8'h02, 0, 0);
    add(0, 32'h0,        1, 1, 8'h04, 8'h01, 1, 1);
    add(0, 32'h0,        1, 0, 8'h00, 8'h00, 0, 1);
    add(1, 32'hDEADBEEF, 1, 0, 8'h00, 8'h00, 0, 1);
    add(0, 32'h0,        1, 1, 8'hDE, 8'hEF, 0, 0);
    add(0, 32'h0,        0, 1, 8'hAD, 8'hBE, 0, 0);
    add(1, 32'h12345678, 0, 1, 8'hAD, 8'hBE, 0, 0);
    add(0, 32'h0,        0, 1, 8'hAD, 8'hBE, 0, 0);
    add(0, 32'h0,        1, 1, 8'hAD, 8'hBE, 0, 0);
    add(0, 32'h0,        1, 1, 8'hBE, 8'hAD, 0, 0);
    add(0, 32'h0,        0, 1, 8'hEF, 8'hDE, 1, 0);
    add(0, 32'h0,        1, 1, 8'hEF, 8'hDE, 1, 1);
    add(0, 32'h0,        1, 0, 8'h00, 8'h00, 0, 1);
    s_caf = vq.size();
    add(1, 32'hCAFEF00D, 1, 0, 8'h00, 8'h00, 0, 1);
    add(0, 32'h0,        1, 1, 8'hCA, 8'h0D, 0, 0);
    add(0, 32'h0,        1, 1, 8'hFE, 8'hF0, 0, 0);
    s_post = vq.size();
    add(1, 32'h55667788, 1, 0, 8'h00, 8'h00, 0, 1);
    add(0, 32'h0,        1, 1, 8'h55, 8'h88, 0, 0);
    add(0, 32'h0,        1, 1, 8'h66, 8'h77, 0, 0);
    add(0, 32'h0,        1, 1, 8'h77, 8'h66, 0, 0);
    add(0, 32'h0,        1, 1, 8'h88, 8'h55, 1, 1);
    add(0, 32'h0,        1, 0, 8'h00, 8'h00, 0, 1);
    s_end = vq.size();

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drv_rts  = 1'($urandom_range(0, 1));
      drv_data = $urandom;
      drv_rtr  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_outs($sformatf("reset%0d", i), 1'b0, 8'h00, 8'h00, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1; drv_rts = 1'b0; drv_rtr = 1'b1;
    @(negedge clk);
    chk_outs("post_reset", 1'b0, 8'h00, 8'h00, 1'b0);
    chk("post_reset m_inp_rtr", {31'd0, m_inp_rtr}, 32'd1);
    chk("post_reset l_inp_rtr", {31'd0, l_inp_rtr}, 32'd1);

    apply_range(s_main, s_caf);

    // Reset in the middle of a word, two slices already sent.
    apply_range(s_caf, s_post);
    @(posedge clk); #1;
    drv_rts = 1'b0;
    chk_outs("mid_word", 1'b1, 8'hF0, 8'hFE, 1'b0);
    rst = 1'b0;
    #1;
    chk_outs("async_reset", 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_outs("reset_release", 1'b0, 8'h00, 8'h00, 1'b0);
    apply_range(s_post, s_end);

    // Fifo-fed stream with random output stalls.
    for (int w = 0; w < 16; w++) begin
      words[w] = $urandom;
      for (int b = 0; b < 4; b++) exp_bytes[w*4 + b] = 8'(words[w] >> (24 - 8*b));
    end
    @(posedge clk); #1;
    use_fifo = 1'b1;
    drv_rts  = 1'b0;
    pushed = 0; got = 0; push_fire = 1'b0;
    for (int cyc = 0; cyc < 3000 && (got < 64 || fifo_count != 0); cyc++) begin
      @(posedge clk); #1;
      if (push_fire) pushed++;
      push_vld = (pushed < 16);
      push_dat = (pushed < 16) ? words[pushed] : 32'h0;
      drv_rtr  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      push_fire = push_vld && push_rdy;
      if (m_rts && drv_rtr) begin
        if (got < 64) begin
          chk($sformatf("stream byte%0d", got), {24'd0, m_data}, {24'd0, exp_bytes[got]});
          chk($sformatf("stream last%0d", got), {31'd0, m_last}, {31'd0, ((got % 4) == 3)});
        end else begin
          chk("stream extra byte", 32'd1, 32'd0);
        end
        got++;
      end
    end
    chk("stream byte count", got, 32'd64);
    chk("stream words pushed", pushed, 32'd16);
    chk("fifo drained", {29'd0, fifo_count}, 32'd0);
    @(negedge clk);
    chk("stream ends idle", {31'd0, m_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
